// File: rtl/output_buffer_fifo.sv
// rtl/output_buffer_fifo.sv - elastic DEPTH-entry register FIFO output stage with level report
module output_buffer_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3,
    parameter int READY_MODE  = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full
);

    localparam int ADDR_WIDTH  = $clog2(DEPTH);
    localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] AF_LEVEL   = LEVEL_WIDTH'(ALMOST_FULL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("output_buffer_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_almost_full
        $error("output_buffer_fifo: ALMOST_FULL must be in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   rst_flag_q, rst_flag_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);

    // Pass-through mode lets a full buffer accept into the slot being freed by the same-cycle pop.
    assign in_ready = (READY_MODE == 0) ? (~rst_flag_q & (~full | out_ready))
                                        : (~rst_flag_q & ~full);

    assign out_valid   = ~empty;
    assign out_data    = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign almost_full = (level_q >= AF_LEVEL);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rst_flag_d = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
            2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rst_flag_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rst_flag_q <= rst_flag_d;
        end
    end

    // Storage is deliberately left out of reset; clearing the pointers discards its contents.
    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

endmodule
